// File: rtl/mem_pkg.sv
// Shared memory-path definitions: size encodings, byte-mask bases,
// store FSM states and the latched-beat bundle.
package mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    WR0,
    WR1,
    DONE,
    ERR
  } state_t;

  typedef struct packed {
    logic [31:0] din;
    logic [3:0]  be;
  } lane_t;

endpackage

// File: rtl/mem_store_align.sv
// Store lane alignment: shifts truncated store data and byte mask
// by the byte offset across a 64-bit (two-word) window.
module mem_store_align
  import mem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [63:0] data,
  output logic [7:0]  mask,
  output logic        split,
  output logic        illegal
);

  logic [31:0] trunc;
  logic [3:0]  base;

  always_comb begin
    trunc   = '0;
    base    = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (size == SIZE_B): begin
        trunc = {24'b0, wdata[7:0]};
        base  = MASK_B;
      end
      (size == SIZE_H): begin
        trunc = {16'b0, wdata[15:0]};
        base  = MASK_H;
      end
      (size == SIZE_W): begin
        trunc = wdata;
        base  = MASK_W;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign data  = {32'b0, trunc} << {off, 3'b000};
  assign mask  = {4'b0, base} << off;
  assign split = |mask[7:4];

endmodule

// File: rtl/mem_write_manager.sv
// Store path: aligns MEM-stage stores to word memory and issues one
// or two word-aligned write beats under a valid/ready handshake.
module mem_write_manager
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  output logic              store_done,
  output logic              store_split,
  output logic              store_err
);

  state_t            state;
  logic [ADDR_W-1:0] b1_addr;
  lane_t             b1;
  logic              split_q;

  logic [63:0]       al_data;
  logic [7:0]        al_mask;
  logic              al_split;
  logic              al_illegal;
  logic [ADDR_W-1:0] a0;

  assign a0 = {req_addr[ADDR_W-1:2], 2'b00};

  mem_store_align u_align (
    .off     (req_addr[1:0]),
    .size    (req_size),
    .wdata   (req_wdata),
    .data    (al_data),
    .mask    (al_mask),
    .split   (al_split),
    .illegal (al_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      mem_be      <= '0;
      store_done  <= 1'b0;
      store_split <= 1'b0;
      store_err   <= 1'b0;
      b1_addr     <= '0;
      b1          <= '0;
      split_q     <= 1'b0;
    end else begin
      store_done  <= 1'b0;
      store_split <= 1'b0;
      store_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (al_illegal) begin
              store_err <= 1'b1;
              state     <= ERR;
            end else begin
              mem_we   <= 1'b1;
              mem_addr <= a0;
              mem_din  <= al_data[31:0];
              mem_be   <= al_mask[3:0];
              // address wraps mod 2^ADDR_W for the second word
              b1_addr  <= a0 + ADDR_W'(4);
              b1.din   <= al_data[63:32];
              b1.be    <= al_mask[7:4];
              split_q  <= al_split;
              state    <= WR0;
            end
          end
        end
        WR0: begin
          if (mem_ready) begin
            if (split_q) begin
              mem_addr <= b1_addr;
              mem_din  <= b1.din;
              mem_be   <= b1.be;
              state    <= WR1;
            end else begin
              mem_we      <= 1'b0;
              mem_be      <= '0;
              store_done  <= 1'b1;
              store_split <= split_q;
              state       <= DONE;
            end
          end
        end
        WR1: begin
          if (mem_ready) begin
            mem_we      <= 1'b0;
            mem_be      <= '0;
            store_done  <= 1'b1;
            store_split <= split_q;
            state       <= DONE;
          end
        end
        DONE, ERR: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          mem_we    <= 1'b0;
          mem_be    <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_manager.sv
// Bench for mem_write_manager: directed vector table, stall/reset
// sequences and random stores against a byte-level store model.
module tb_mem_write_manager;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b1;
  logic        store_done;
  logic        store_split;
  logic        store_err;

  always #5 clk = ~clk;

  mem_write_manager #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_size    (req_size),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_be      (mem_be),
    .mem_ready   (mem_ready),
    .store_done  (store_done),
    .store_split (store_split),
    .store_err   (store_err)
  );

  int checks = 0;
  int failures = 0;

  // expected transaction
  int          exp_n;
  logic        exp_err;
  logic [31:0] exp_a [2];
  logic [3:0]  exp_be[2];
  logic [31:0] exp_d [2];

  // observed transaction
  int          obs_n;
  logic [31:0] obs_a [4];
  logic [3:0]  obs_be[4];
  logic [31:0] obs_d [4];
  int          obs_done_k;
  int          obs_err_k;
  logic        obs_split;
  int          obs_stalls;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    int          n;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Byte-by-byte placement: each stored byte lands at its own
  // address; the words it touches become the expected beats.
  task automatic model(input logic [31:0] addr,
                       input logic [31:0] data,
                       input logic [1:0]  size);
    int nb;
    logic [31:0] w0, ba, w;
    int idx, lane;
    exp_n = 0;
    exp_err = (size == 2'b11);
    for (int i = 0; i < 2; i++) begin
      exp_a[i] = '0; exp_be[i] = '0; exp_d[i] = '0;
    end
    if (exp_err) return;
    nb = 1 << size;
    w0 = addr & 32'hFFFF_FFFC;
    for (int k = 0; k < nb; k++) begin
      ba = addr + 32'(k);
      w = ba & 32'hFFFF_FFFC;
      lane = int'(ba[1:0]);
      idx = (w == w0) ? 0 : 1;
      exp_a[idx] = w;
      exp_be[idx][lane] = 1'b1;
      exp_d[idx][8*lane +: 8] = data[8*k +: 8];
      if (idx + 1 > exp_n) exp_n = idx + 1;
    end
  endtask

  // mode 0: mem_ready high; 1: random; 2: 3 low cycles on beat 0
  task automatic do_txn(input logic [31:0] addr,
                        input logic [31:0] data,
                        input logic [1:0]  size,
                        input int mode,
                        input bit hold,
                        input string tag);
    logic prev_hold;
    logic [68:0] prev;
    int stall_left;
    bit fin;
    obs_n = 0; obs_done_k = -1; obs_err_k = -1;
    obs_split = 1'b0; obs_stalls = 0;
    prev_hold = 1'b0; prev = '0;
    stall_left = 3; fin = 0;
    chk({tag, " ready_idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_wdata = data;
    req_size  = size;
    mem_ready = 1'b1;
    for (int k = 1; k <= 60 && !fin; k++) begin
      @(negedge clk);
      if (prev_hold)
        chk({tag, " stable"},
            64'({mem_we, mem_addr, mem_din, mem_be}),
            64'(prev));
      chk({tag, " busy"}, 64'(req_ready), 64'd0);
      chk({tag, " excl"}, 64'(store_done & store_err), 64'd0);
      if (!mem_we) chk({tag, " be_idle"}, 64'(mem_be), 64'd0);
      if (store_done) begin
        obs_done_k = k; obs_split = store_split; fin = 1;
      end
      if (store_err) begin
        obs_err_k = k; fin = 1;
      end
      if (!hold || fin) req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_size  = 2'($urandom_range(0, 3));
      if (mem_we) begin
        mem_ready = 1'b1;
        if (mode == 1) mem_ready = ($urandom_range(0, 2) != 0);
        if (mode == 2 && obs_n == 0 && stall_left > 0) begin
          mem_ready = 1'b0;
          stall_left--;
        end
        if (mem_ready && obs_n < 4) begin
          obs_a[obs_n] = mem_addr;
          obs_be[obs_n] = mem_be;
          obs_d[obs_n] = mem_din;
          obs_n++;
        end
        if (!mem_ready) obs_stalls++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      prev_hold = mem_we && !mem_ready;
      prev = {mem_we, mem_addr, mem_din, mem_be};
    end
    if (!fin) begin
      failures++;
      $display("FAIL %s timeout: got none expected done", tag);
    end
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk({tag, " ready_back"}, 64'(req_ready), 64'd1);
    chk({tag, " we_back"}, 64'(mem_we), 64'd0);
  endtask

  task automatic compare(input string tag);
    chk({tag, " err"}, 64'(obs_err_k >= 0), 64'(exp_err));
    if (exp_err) begin
      chk({tag, " err_lat"}, 64'(obs_err_k), 64'd1);
      chk({tag, " err_beats"}, 64'(obs_n), 64'd0);
    end else begin
      chk({tag, " beats"}, 64'(obs_n), 64'(exp_n));
      for (int i = 0; i < exp_n && i < obs_n; i++) begin
        chk($sformatf("%s addr%0d", tag, i), 64'(obs_a[i]), 64'(exp_a[i]));
        chk($sformatf("%s be%0d", tag, i), 64'(obs_be[i]), 64'(exp_be[i]));
        chk($sformatf("%s din%0d", tag, i), 64'(obs_d[i]), 64'(exp_d[i]));
      end
      chk({tag, " split"}, 64'(obs_split), 64'(exp_n == 2));
      chk({tag, " done_lat"}, 64'(obs_done_k),
          64'(1 + exp_n + obs_stalls));
    end
  endtask

  task automatic load_vec(input vec_t v);
    exp_err = 1'b0;
    exp_n = v.n;
    exp_a[0] = v.a0; exp_be[0] = v.be0; exp_d[0] = v.d0;
    exp_a[1] = v.a1; exp_be[1] = v.be1; exp_d[1] = v.d1;
  endtask

  initial begin
    vecs[0] = '{32'h1003, 32'hAABBCC5A, 2'b00, 1,
                32'h1000, 4'b1000, 32'h5A00_0000, 0, 0, 0};
    vecs[1] = '{32'h2002, 32'h0000BEEF, 2'b01, 1,
                32'h2000, 4'b1100, 32'hBEEF_0000, 0, 0, 0};
    vecs[2] = '{32'h3001, 32'h11223344, 2'b10, 2,
                32'h3000, 4'b1110, 32'h2233_4400,
                32'h3004, 4'b0001, 32'h0000_0011};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000CAFE, 2'b01, 2,
                32'hFFFF_FFFC, 4'b1000, 32'hFE00_0000,
                32'h0000_0000, 4'b0001, 32'h0000_00CA};
    vecs[4] = '{32'h4000, 32'h12345678, 2'b10, 1,
                32'h4000, 4'b1111, 32'h1234_5678, 0, 0, 0};
    vecs[5] = '{32'h5001, 32'hDEADBEEF, 2'b00, 1,
                32'h5000, 4'b0010, 32'h0000_EF00, 0, 0, 0};
    vecs[6] = '{32'h6003, 32'h0000ABCD, 2'b01, 2,
                32'h6000, 4'b1000, 32'hCD00_0000,
                32'h6004, 4'b0001, 32'h0000_00AB};

    #12;
    chk("rst ready", 64'(req_ready), 64'd1);
    chk("rst outs", 64'({mem_we, mem_be, store_done,
                         store_split, store_err}), 64'd0);
    chk("rst addr_din", {mem_addr, mem_din}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_txn(vecs[i].addr, vecs[i].data, vecs[i].size, 0, 0,
             $sformatf("vec%0d", i));
      load_vec(vecs[i]);
      compare($sformatf("vec%0d", i));
    end

    do_txn(32'h3001, 32'h11223344, 2'b10, 2, 1, "stall3");
    load_vec(vecs[2]);
    compare("stall3");
    chk("stall3 count", 64'(obs_stalls), 64'd3);
    chk("stall3 done", 64'(obs_done_k), 64'd6);

    do_txn(32'h7000, 32'h55AA55AA, 2'b11, 0, 0, "illegal");
    model(32'h7000, 32'h55AA55AA, 2'b11);
    compare("illegal");

    // reset while beat 0 of a split store is pending
    req_valid = 1'b1;
    req_addr = 32'h8002;
    req_wdata = 32'hA1B2C3D4;
    req_size = 2'b10;
    mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid we", 64'(mem_we), 64'd1);
    chk("rst_mid addr", 64'(mem_addr), 64'h8000);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid drop", 64'({mem_we, mem_be}), 64'd0);
    chk("rst_mid ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst quiet",
          64'({mem_we, store_done, store_err}), 64'd0);
      chk("post_rst ready", 64'(req_ready), 64'd1);
    end

    for (int r = 0; r < 40; r++) begin
      logic [31:0] a, d;
      logic [1:0] s;
      a = $urandom;
      if (r % 4 == 0) a[31:2] = '1;
      d = $urandom;
      s = 2'($urandom_range(0, 3));
      do_txn(a, d, s, r % 2, r[2], $sformatf("rnd%0d", r));
      model(a, d, s);
      compare($sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_write_manager.md
# mem_write_manager

Store-path counterpart of the load data formatter. Accepts one store request per transaction from the pipeline MEM stage (address, 32-bit register data, size), aligns data and byte enables to the 32-bit word-organised data memory, and issues word-aligned writes. Stores crossing a word boundary are split into two sequential aligned beats by an internal FSM. The pipeline stalls on `req_ready` low.

## Interface
- `ADDR_W`, 32, byte address width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  store request present
- `req_ready`  out  1  block idle, request accepted this cycle if `req_valid`
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  32  store data, LSB-justified (`rs2`)
- `req_size`  in  2  00 byte, 01 half-word, 10 word, 11 illegal
- `mem_we`  out  1  write beat valid
- `mem_addr`  out  ADDR_W  word-aligned address, bits [1:0] always 0
- `mem_din`  out  32  lane-aligned write data
- `mem_be`  out  4  byte enables, bit i covers `mem_din[8i+7:8i]`
- `mem_ready`  in  1  memory accepts beat when `mem_we && mem_ready`
- `store_done`  out  1  one-cycle pulse, transaction finished
- `store_split`  out  1  valid with `store_done`: transaction used two beats
- `store_err`  out  1  one-cycle pulse, illegal size, nothing written

## Operation
- Alignment on accept, `off = req_addr[1:0]`:
  - 64-bit data = `{32'b0, req_wdata} << (8*off)`; 8-bit mask = base `<< off`, base 0001 (byte), 0011 (half), 1111 (word).
  - Beat 0: addr `{req_addr[ADDR_W-1:2],2'b00}`, data/mask low halves.
  - Beat 1 only if mask[7:4] != 0: addr = beat-0 addr + 4 (mod 2^ADDR_W, 0xFFFFFFFC wraps to 0x00000000), data/mask high halves.
- Sizes 00/01/10 truncate `req_wdata` to 8/16/32 bits. No sign handling.
- FSM states:
  - IDLE: `req_ready`=1. On accept with legal size: latch both beats, -> WR0. Illegal size: -> ERR.
  - WR0: drive beat 0. On `mem_ready`: -> WR1 if split, else -> DONE.
  - WR1: drive beat 1. On `mem_ready`: -> DONE.
  - DONE: `store_done`=1, `store_split` = latched split flag; -> IDLE.
  - ERR: `store_err`=1; -> IDLE. No `mem_we` ever asserted.
- `mem_*` outputs driven from registers and held stable while `mem_ready` low. `mem_we`=0 and `mem_be`=0 outside WR0/WR1.
- `req_*` sampled only on the accept cycle; later changes ignored.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, `req_ready`=1, all other outputs 0, latched beats cleared.
- Reset mid-transaction aborts immediately: `mem_we` drops asynchronously; a pending second beat is never issued.
- Latency with `mem_ready` tied high: aligned store = accept cycle, WR0, DONE (`store_done` 2 cycles after accept, next accept 3 cycles after). Split store adds one cycle (WR1).
- Each `mem_ready` low cycle in WR0/WR1 adds exactly one cycle.
- Illegal size: `store_err` 1 cycle after accept, `req_ready` back 2 cycles after accept.
- `store_done` and `store_err` never asserted together; at most one pulse per accepted request.

## Structure
- Shared package `mem_pkg`: size encodings (`SIZE_B`=2'b00, `SIZE_H`=2'b01, `SIZE_W`=2'b10), FSM state type (IDLE, WR0, WR1, DONE, ERR), base byte-mask constants. Same size encodings as the load path.
- One combinational sub-module `mem_store_align`: (addr offset, size, wdata) -> 64-bit shifted data, 8-bit mask, split flag, illegal flag. FSM and beat registers stay in `mem_write_manager`.

## Test plan
- Byte store, addr 0x1003, wdata 0xAABBCC5A, `mem_ready`=1 -> one beat: addr 0x1000, be 1000, din[31:24]=0x5A; `store_done` 2 cycles after accept, `store_split`=0.
- Half-word at 0x2002, wdata 0x0000BEEF -> addr 0x2000, be 1100, din 0xBEEF0000; no split.
- Word at 0x3001, wdata 0x11223344 -> beat 0: 0x3000, be 1110, din 0x22334400; beat 1: 0x3004, be 0001, din 0x00000011; `store_split`=1.
- Half-word at 0xFFFFFFFF, wdata 0xCAFE -> beat 0: 0xFFFFFFFC, be 1000, din[31:24]=0xFE; beat 1: 0x00000000, be 0001, din[7:0]=0xCA.
- `mem_ready` low 3 cycles during beat 0 of a split word store -> outputs stable throughout, beat 1 follows the handshake, `store_done` 3 cycles later than with `mem_ready`=1; `req_valid` held high is not re-accepted before `req_ready`.
- `req_size`=11 -> no `mem_we`, `store_err` pulse 1 cycle after accept; `rst_n` asserted while in WR0 of a split store -> `mem_we` drops, beat 1 never issued, block idle after release.
